alu_result_stage: RTL and testbench

//  Pipeline stage directly downstream of the ALU. Registers result/dest/write-enable with a

---
 rtl/alu_result_stage_if.sv | 51 +++++
 rtl/alu_result_stage.sv | 107 ++++++++++
 tb/tb_alu_result_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - handshake, flag and condition bundle for alu_result_stage
//
// Purpose: groups every non-clock signal of the ALU result stage.
//   master modport : ALU / jump-unit / regfile side (testbench drives this)
//   slave  modport : the result stage itself
// Signals:
//   in_valid/in_ready, in_op, in_result, in_O/S/C/Z, in_rd, in_wen, in_setflags : ALU input stream
//   out_valid/out_ready, out_result, out_rd, out_wen                          : registered output stream
//   flag_O/S/C/Z                                                              : committed flag register
//   cond_sel/cond_true                                                        : branch condition query
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [WIDTH-1:0] in_result;
  logic             in_O;
  logic             in_S;
  logic             in_C;
  logic             in_Z;
  logic [RD_W-1:0]  in_rd;
  logic             in_wen;
  logic             in_setflags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wen;
  logic             flag_O;
  logic             flag_S;
  logic             flag_C;
  logic             flag_Z;
  logic [2:0]       cond_sel;
  logic             cond_true;

  modport master (
    output in_valid, in_op, in_result, in_O, in_S, in_C, in_Z, in_rd, in_wen, in_setflags,
    output out_ready, cond_sel,
    input  in_ready, out_valid, out_result, out_rd, out_wen,
    input  flag_O, flag_S, flag_C, flag_Z, cond_true
  );

  modport slave (
    input  in_valid, in_op, in_result, in_O, in_S, in_C, in_Z, in_rd, in_wen, in_setflags,
    input  out_ready, cond_sel,
    output in_ready, out_valid, out_result, out_rd, out_wen,
    output flag_O, flag_S, flag_C, flag_Z, cond_true
  );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result register stage with flag register and branch condition
//
// Purpose: single-entry valid/ready register behind the ALU. Latches result, destination
// and write enable; commits O/S/C/Z flags on acceptance according to the op class; evaluates
// the branch condition selected by cond_sel against the committed flags.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : alu_result_stage_if.slave (input stream, output stream, flags, condition)
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_result_stage_if.slave   bus
);

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic [RD_W-1:0]  rd_q;
  logic             wen_q;
  logic             o_q;
  logic             s_q;
  logic             c_q;
  logic             z_q;

  logic             ready;
  logic             transfer;
  logic             cls_arith;
  logic             cls_shift;
  logic             cls_logic;

  // Full throughput: an occupied register still accepts when it drains on the same edge.
  assign ready    = !valid_q || bus.out_ready;
  assign transfer = bus.in_valid && ready;

  // Op classes that touch flags; everything else in 01xxx (loadlit/lcl/lch, ...) leaves them.
  assign cls_arith = (bus.in_op[4:3] == 2'b00);
  assign cls_shift = (bus.in_op[4:1] == 4'b0100);
  assign cls_logic = bus.in_op[4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      o_q      <= 1'b0;
      s_q      <= 1'b0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else if (transfer) begin
      valid_q  <= 1'b1;
      result_q <= bus.in_result;
      rd_q     <= bus.in_rd;
      wen_q    <= bus.in_wen;
      // Flags commit at acceptance so a stalled consumer never delays them.
      if (bus.in_setflags) begin
        if (cls_arith) begin
          o_q <= bus.in_O;
          s_q <= bus.in_S;
          c_q <= bus.in_C;
          z_q <= bus.in_Z;
        end else if (cls_shift) begin
          o_q <= 1'b0;
          s_q <= bus.in_S;
          c_q <= bus.in_C;
          z_q <= bus.in_Z;
        end else if (cls_logic) begin
          o_q <= 1'b0;
          s_q <= bus.in_S;
          c_q <= 1'b0;
          z_q <= bus.in_Z;
        end
      end
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Condition uses committed flags only; an in-flight update is not forwarded.
  always_comb begin
    bus.cond_true = 1'b0;
    case (bus.cond_sel)
      3'b000:  bus.cond_true = 1'b1;
      3'b001:  bus.cond_true = z_q;
      3'b010:  bus.cond_true = !z_q;
      3'b011:  bus.cond_true = s_q;
      3'b100:  bus.cond_true = !s_q;
      3'b101:  bus.cond_true = c_q;
      3'b110:  bus.cond_true = o_q;
      default: bus.cond_true = 1'b0;
    endcase
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_wen    = wen_q;
  assign bus.flag_O     = o_q;
  assign bus.flag_S     = s_q;
  assign bus.flag_C     = c_q;
  assign bus.flag_Z     = z_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard testbench for alu_result_stage
module tb_alu_result_stage;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  rd;
    logic        w;
  } ent_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   n_acc;
  ent_t exp_q[$];
  logic m_o, m_s, m_c, m_z;

  alu_result_stage_if #(.WIDTH(32), .RD_W(4)) bus ();

  alu_result_stage #(.WIDTH(32), .RD_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_model(input logic [2:0] sel);
    case (sel)
      3'd0: return 1'b1;
      3'd1: return m_z;
      3'd2: return !m_z;
      3'd3: return m_s;
      3'd4: return !m_s;
      3'd5: return m_c;
      3'd6: return m_o;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: accepted entry goes to the scoreboard; flags follow the op-class rules.
  task automatic accept();
    int op;
    exp_q.push_back('{r: bus.in_result, rd: bus.in_rd, w: bus.in_wen});
    n_acc++;
    if (bus.in_setflags) begin
      op = int'(bus.in_op);
      if (op < 8) begin
        m_o = bus.in_O; m_s = bus.in_S; m_c = bus.in_C; m_z = bus.in_Z;
      end else if (op == 8 || op == 9) begin
        m_o = 1'b0; m_s = bus.in_S; m_c = bus.in_C; m_z = bus.in_Z;
      end else if (op >= 16) begin
        m_o = 1'b0; m_s = bus.in_S; m_c = 1'b0; m_z = bus.in_Z;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] res,
                       input logic [3:0] f, input logic [3:0] rd, input logic wen,
                       input logic sf);
    bus.in_valid    = v;
    bus.in_op       = op;
    bus.in_result   = res;
    {bus.in_O, bus.in_S, bus.in_C, bus.in_Z} = f;
    bus.in_rd       = rd;
    bus.in_wen      = wen;
    bus.in_setflags = sf;
  endtask

  // One clock: decide acceptance on the stable negedge, commit the model at the edge.
  task automatic step();
    logic wx;
    @(negedge clk);
    wx = bus.in_valid && bus.in_ready && !reset;
    @(posedge clk);
    if (wx) accept();
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {bus.flag_O, bus.flag_S, bus.flag_C, bus.flag_Z};
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'((exp_q.size() == 0) || bus.out_ready));
      chk("flags", 64'(flags()), 64'({m_o, m_s, m_c, m_z}));
      chk("cond_true", 64'(bus.cond_true), 64'(cond_model(bus.cond_sel)));
      if (bus.out_valid && exp_q.size() != 0) begin
        chk("out_result", 64'(bus.out_result), 64'(exp_q[0].r));
        chk("out_rd", 64'(bus.out_rd), 64'(exp_q[0].rd));
        chk("out_wen", 64'(bus.out_wen), 64'(exp_q[0].w));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int acc0;
    tests = 0; fails = 0; n_acc = 0;
    m_o = 0; m_s = 0; m_c = 0; m_z = 0;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    bus.cond_sel  = 3'd0;
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_flags", 64'(flags()), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-stream: entry accepted with flags set, reset before it drains.
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd0, 32'hDEADBEEF, 4'hF, 4'd3, 1'b1, 1'b1);
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    chk("pre_reset_flags", 64'(flags()), 64'hF);
    #2;
    reset = 1'b1;
    exp_q.delete();
    m_o = 0; m_s = 0; m_c = 0; m_z = 0;
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset_out_result", 64'(bus.out_result), 64'd0);
    chk("midreset_flags", 64'(flags()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;

    // add 0xFFFFFFFF + 1: carry and zero.
    drive(1'b1, 5'd0, 32'h0, 4'b0011, 4'd1, 1'b1, 1'b1);
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    bus.cond_sel = 3'b001;
    #1;
    chk("add_out_result", 64'(bus.out_result), 64'd0);
    chk("add_flags", 64'(flags()), 64'b0011);
    chk("add_cond_z", 64'(bus.cond_true), 64'd1);
    step();

    // Stall three cycles with a waiting word, then drain and fill on one edge.
    drive(1'b1, 5'd1, 32'h1111_2222, 4'h0, 4'd4, 1'b1, 1'b0);
    step();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd2, 32'h3333_4444, 4'hF, 4'd5, 1'b1, 1'b1);
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_result", 64'(bus.out_result), 64'h1111_2222);
    end
    chk("stall_no_accept", 64'(n_acc - acc0), 64'd0);
    bus.out_ready = 1'b1;
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    chk("refill_result", 64'(bus.out_result), 64'h3333_4444);
    chk("refill_valid", 64'(bus.out_valid), 64'd1);
    chk("refill_flags", 64'(flags()), 64'hF);
    step();

    // Set C and O, then xor clears them and sets S.
    drive(1'b1, 5'd0, 32'd5, 4'b1010, 4'd2, 1'b1, 1'b1);
    step();
    chk("co_flags", 64'(flags()), 64'b1010);
    drive(1'b1, 5'b10110, 32'h8000_0000, 4'b1110, 4'd2, 1'b1, 1'b1);
    step();
    chk("xor_flags", 64'(flags()), 64'b0100);

    // lch leaves flags alone while still loading the result.
    drive(1'b1, 5'b01110, 32'hABCD_0000, 4'b1011, 4'd7, 1'b1, 1'b1);
    step();
    chk("lch_flags", 64'(flags()), 64'b0100);
    chk("lch_result", 64'(bus.out_result), 64'hABCD_0000);
    chk("lch_wen", 64'(bus.out_wen), 64'd1);

    // Four back-to-back transfers.
    acc0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'h100 + 32'(i), 4'h0, 4'(i), 1'(i), 1'b0);
      step();
    end
    chk("b2b_accepts", 64'(n_acc - acc0), 64'd4);
    drive(1'b0, 5'd0, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
            4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.cond_sel  = 3'($urandom);
      step();
    end

    drive(1'b0, 5'd0, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
